fsm_papsel_gen: RTL
===================

FSM_PAPSEL_GEN -- requirements
Module: fsm_papsel_gen

Interface
REQ-001 The block SHALL have parameter SYM_W, default 3, symbol width in bits.
REQ-002 The block SHALL have parameter MIN_LEN, default 2, minimum legal frame length in symbols.
REQ-003 The block SHALL have parameter MAX_LEN, default 8, maximum legal frame length in symbols.
REQ-004 The block SHALL have parameter GAP, default 2, number of consecutive invalid cycles that closes a frame (GAP >= 1).
REQ-005 The block SHALL have parameter SOF_SYM, default 1, required value of the first symbol.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port m_in, input, SYM_W, symbol, sampled only when m_in_vld=1.
REQ-009 The block SHALL have port m_in_vld, input, 1, symbol valid.
REQ-010 The block SHALL have port qout, output, 1, one-cycle frame-report strobe.
REQ-011 The block SHALL have port check, output, 3, frame result code, valid while qout=1.
REQ-012 The block SHALL have port frm_len, output, $clog2(MAX_LEN+2), frame length, valid while qout=1.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and REPORT.
REQ-014 IDLE: m_in_vld=1 -> RUN; the symbol is the first of the frame, length=1.
REQ-015 RUN: m_in_vld=1 -> length+1, gap counter cleared.
REQ-016 RUN: m_in_vld=0 -> gap counter+1; on the GAP-th consecutive invalid cycle -> REPORT.
REQ-017 Fewer than GAP invalid cycles followed by a valid symbol SHALL continue the same frame.
REQ-018 REPORT SHALL last exactly one cycle with qout=1, check and frm_len driven from registers; otherwise qout=0, check=0, frm_len=0.
REQ-019 REPORT with m_in_vld=1 SHALL go to RUN with that symbol as first of a new frame (no symbol lost); otherwise -> IDLE.
REQ-020 Length SHALL saturate at MAX_LEN+1.
REQ-021 check codes, highest priority first: 3 first symbol != SOF_SYM; 1 length < MIN_LEN; 2 length > MAX_LEN; 4 checksum error (REQ-026); 0 OK.
REQ-022 qout SHALL be asserted the cycle after the GAP-th invalid cycle is sampled; latency from last valid symbol = GAP+1 cycles.

Reset
REQ-023 rstn low SHALL immediately force IDLE, qout=0, check=0, frm_len=0, counters and checksum cleared.
REQ-024 A frame in progress at reset SHALL be discarded and never reported.
REQ-025 The first symbol SHALL be accepted on the first rising edge with rstn high.

Configuration
REQ-026 With PAPSEL_CKSUM_EN defined, the block SHALL XOR all frame symbols and report code 4 when the result is nonzero and no higher-priority code applies.
REQ-027 Without PAPSEL_CKSUM_EN, no checksum register SHALL exist and code 4 SHALL never be produced.

Structure
REQ-028 Package fsm_papsel_pkg SHALL hold the state enum and the check-code constants (CHK_OK=0, CHK_SHORT=1, CHK_LONG=2, CHK_SOF=3, CHK_CKSUM=4).
REQ-029 The frame-length/gap counter pair SHALL be a sub-module papsel_frm_cnt; everything else stays in fsm_papsel_gen.

Verification (defaults, PAPSEL_CKSUM_EN defined unless stated)
REQ-030 Symbols 1,5,4 then 2 idle cycles -> one qout pulse, check=0, frm_len=3.
REQ-031 Single symbol 1 -> check=1, frm_len=1; single symbol 2 -> check=3, frm_len=1.
REQ-032 Nine consecutive symbols 1 -> check=2, frm_len=9 (saturated); 1,1,1 -> check=4 with macro, check=0 without.
REQ-033 Symbols 1, one idle cycle, 1, two idle cycles -> single frame, check=0, frm_len=2; new symbol 1 during REPORT -> next frame starts, length counts it.
REQ-034 rstn pulsed low mid-frame after 1,5 -> qout never asserted for that frame, all outputs 0 during reset.

Source files
------------

// File: rtl/fsm_papsel_pkg.sv
// Shared types and result codes for the frame checker fsm_papsel_gen.
package fsm_papsel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [2:0] CHK_OK    = 3'd0;
    localparam logic [2:0] CHK_SHORT = 3'd1;
    localparam logic [2:0] CHK_LONG  = 3'd2;
    localparam logic [2:0] CHK_SOF   = 3'd3;
    localparam logic [2:0] CHK_CKSUM = 3'd4;

endpackage

// File: rtl/papsel_frm_cnt.sv
// Frame-length (saturating at MAX_LEN+1) and inter-symbol gap counter pair.
module papsel_frm_cnt #(
    parameter int MAX_LEN = 8,
    parameter int GAP     = 2,
    parameter int LW      = $clog2(MAX_LEN + 2),
    parameter int GW      = $clog2(GAP + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_clr,
    input  logic          i_start,
    input  logic          i_inc,
    input  logic          i_gap,
    output logic [LW-1:0] o_len,
    output logic          o_gap_last
);

    localparam logic [LW-1:0] LEN_SAT  = LW'(MAX_LEN + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    logic [LW-1:0] r_len;
    logic [GW-1:0] r_gap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len <= '0;
            r_gap <= '0;
        end else if (i_clr) begin
            r_len <= '0;
            r_gap <= '0;
        end else if (i_start) begin
            r_len <= LW'(1);
            r_gap <= '0;
        end else if (i_inc) begin
            if (r_len != LEN_SAT)
                r_len <= r_len + LW'(1);
            r_gap <= '0;
        end else if (i_gap) begin
            r_gap <= r_gap + GW'(1);
        end
    end

    assign o_len      = r_len;
    assign o_gap_last = (r_gap == GAP_LAST);

endmodule

// File: rtl/fsm_papsel_gen.sv
// Frame delimiter/checker: frames close after GAP idle cycles and are reported once.
// Optional XOR checksum check is enabled by defining PAPSEL_CKSUM_EN.
module fsm_papsel_gen
    import fsm_papsel_pkg::*;
#(
    parameter int SYM_W   = 3,
    parameter int MIN_LEN = 2,
    parameter int MAX_LEN = 8,
    parameter int GAP     = 2,
    parameter int SOF_SYM = 1,
    parameter int LW      = $clog2(MAX_LEN + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SYM_W-1:0] m_in,
    input  logic             m_in_vld,
    output logic             qout,
    output logic [2:0]       check,
    output logic [LW-1:0]    frm_len
);

    localparam logic [SYM_W-1:0] SOF_V = SYM_W'(SOF_SYM);
    localparam logic [LW-1:0]    MIN_V = LW'(MIN_LEN);
    localparam logic [LW-1:0]    MAX_V = LW'(MAX_LEN);

    state_t           r_state, w_nxt;
    logic             w_clr, w_start, w_inc, w_gap, w_rpt;
    logic [LW-1:0]    w_len;
    logic             w_gap_last;
    logic [2:0]       w_code;
    logic [SYM_W-1:0] r_first;
    logic             r_qout;
    logic [2:0]       r_check;
    logic [LW-1:0]    r_len;

    papsel_frm_cnt #(
        .MAX_LEN (MAX_LEN),
        .GAP     (GAP),
        .LW      (LW)
    ) u_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_clr),
        .i_start    (w_start),
        .i_inc      (w_inc),
        .i_gap      (w_gap),
        .o_len      (w_len),
        .o_gap_last (w_gap_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt   = r_state;
        w_clr   = 1'b0;
        w_start = 1'b0;
        w_inc   = 1'b0;
        w_gap   = 1'b0;
        w_rpt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (m_in_vld) begin
                    w_nxt   = RUN;
                    w_start = 1'b1;
                end
            end
            RUN: begin
                if (m_in_vld) begin
                    w_inc = 1'b1;
                end else if (w_gap_last) begin
                    w_nxt = REPORT;
                    w_rpt = 1'b1;
                end else begin
                    w_gap = 1'b1;
                end
            end
            REPORT: begin
                // A symbol arriving while reporting opens the next frame directly.
                if (m_in_vld) begin
                    w_nxt   = RUN;
                    w_start = 1'b1;
                end else begin
                    w_nxt = IDLE;
                    w_clr = 1'b1;
                end
            end
            default: begin
                w_nxt = IDLE;
                w_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_first <= '0;
        else if (w_start) r_first <= m_in;
    end

`ifdef PAPSEL_CKSUM_EN
    logic [SYM_W-1:0] r_cksum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_cksum <= '0;
        else if (w_start) r_cksum <= m_in;
        else if (w_inc)   r_cksum <= r_cksum ^ m_in;
    end
`endif

    always_comb begin
        w_code = CHK_OK;
        if (r_first != SOF_V)  w_code = CHK_SOF;
        else if (w_len < MIN_V) w_code = CHK_SHORT;
        else if (w_len > MAX_V) w_code = CHK_LONG;
`ifdef PAPSEL_CKSUM_EN
        else if (r_cksum != '0) w_code = CHK_CKSUM;
`endif
    end

    // Report outputs are registered so they are zero outside the REPORT cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_qout  <= 1'b0;
            r_check <= CHK_OK;
            r_len   <= '0;
        end else begin
            r_qout  <= w_rpt;
            r_check <= w_rpt ? w_code : CHK_OK;
            r_len   <= w_rpt ? w_len  : '0;
        end
    end

    assign qout    = r_qout;
    assign check   = r_check;
    assign frm_len = r_len;

endmodule
